// File: rtl/axil_pkg.sv
// Shared AXI4-Lite decoder types: response codes, FSM state encodings and
// the index-width helper used by the decoder and its address-decode slices.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_OUT} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_DATA, R_OUT} rd_state_t;

  // A single target still needs a one-bit index so the ports never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axil_decoder_1ton_if.sv
// Upstream AXI4-Lite bus bundle; the decoder binds to the slave modport and
// the manager (or bench) to the master modport.
interface axil_decoder_1ton_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_addr_decode.sv
// Combinational region decoder: the address bits above REGION_BITS select the
// target; anything at or beyond NUM_TARGETS is reported as a miss.
module axil_addr_decode
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int REGION_BITS = 4,
    parameter int NUM_TARGETS = 2,
    parameter int IDX_W       = idx_width(NUM_TARGETS)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  hit,
    output logic [IDX_W-1:0]      idx
);
    logic [ADDR_WIDTH-1:0] region;

    assign region = addr >> REGION_BITS;
    assign hit    = region < ADDR_WIDTH'(NUM_TARGETS);
    assign idx    = region[IDX_W-1:0];
endmodule

// File: rtl/axil_decoder_1ton.sv
// One-to-N AXI4-Lite address decoder with independent single-outstanding
// write and read FSMs. Define AXIL_DEC_TIMEOUT_EN to add per-path watchdogs.
module axil_decoder_1ton
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int NUM_TARGETS    = 2,
    parameter int REGION_BITS    = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                              s0_axi_aclk,
    input  logic                              s0_axi_aresetn,
    axil_decoder_1ton_if.slave                s0_axi,
    output logic [NUM_TARGETS*ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [NUM_TARGETS-1:0]            m_axi_awvalid,
    input  logic [NUM_TARGETS-1:0]            m_axi_awready,
    output logic [NUM_TARGETS*DATA_WIDTH-1:0] m_axi_wdata,
    output logic [NUM_TARGETS*DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic [NUM_TARGETS-1:0]            m_axi_wvalid,
    input  logic [NUM_TARGETS-1:0]            m_axi_wready,
    input  logic [NUM_TARGETS*2-1:0]          m_axi_bresp,
    input  logic [NUM_TARGETS-1:0]            m_axi_bvalid,
    output logic [NUM_TARGETS-1:0]            m_axi_bready,
    output logic [NUM_TARGETS*ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [NUM_TARGETS-1:0]            m_axi_arvalid,
    input  logic [NUM_TARGETS-1:0]            m_axi_arready,
    input  logic [NUM_TARGETS*DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [NUM_TARGETS*2-1:0]          m_axi_rresp,
    input  logic [NUM_TARGETS-1:0]            m_axi_rvalid,
    output logic [NUM_TARGETS-1:0]            m_axi_rready
);
    localparam int IDX_W  = idx_width(NUM_TARGETS);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [1:0]            m_bresp_a [NUM_TARGETS];
    logic [1:0]            m_rresp_a [NUM_TARGETS];
    logic [DATA_WIDTH-1:0] m_rdata_a [NUM_TARGETS];

    for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_unpack
        assign m_bresp_a[g] = m_axi_bresp[g*2 +: 2];
        assign m_rresp_a[g] = m_axi_rresp[g*2 +: 2];
        assign m_rdata_a[g] = m_axi_rdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // ---------------- write path ----------------
    wr_state_t             wr_state, wr_next;
    logic                  awready_q, awready_d, wready_q, wready_d;
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [IDX_W-1:0]      widx_q, widx_d;
    logic                  aw_v_q, aw_v_d, w_v_q, w_v_d, bready_q, bready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  aw_hs, w_hs, aw_have, w_have;
    logic [ADDR_WIDTH-1:0] wr_dec_addr;
    logic                  wr_hit;
    logic [IDX_W-1:0]      wr_idx;

    // AW may have been captured earlier while W is still outstanding.
    assign wr_dec_addr = aw_held_q ? awaddr_q : s0_axi.awaddr;

    axil_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .REGION_BITS(REGION_BITS),
        .NUM_TARGETS(NUM_TARGETS),
        .IDX_W      (IDX_W)
    ) u_wr_dec (
        .addr(wr_dec_addr),
        .hit (wr_hit),
        .idx (wr_idx)
    );

`ifdef AXIL_DEC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
`endif

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
        wr_next   = wr_state;
        awready_d = awready_q;
        wready_d  = wready_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        widx_d    = widx_q;
        aw_v_d    = aw_v_q;
        w_v_d     = w_v_q;
        bready_d  = bready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        aw_hs     = awready_q & s0_axi.awvalid;
        w_hs      = wready_q & s0_axi.wvalid;
        aw_have   = aw_held_q | aw_hs;
        w_have    = w_held_q | w_hs;
        case (wr_state)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s0_axi.awaddr;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = s0_axi.wdata;
                    wstrb_d  = s0_axi.wstrb;
                end
                awready_d = !aw_have;
                wready_d  = !w_have;
                if (aw_have && w_have) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    widx_d    = wr_idx;
                    if (wr_hit) begin
                        wr_next = W_FWD;
                        aw_v_d  = 1'b1;
                        w_v_d   = 1'b1;
                    end else begin
                        wr_next  = W_OUT;
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_DECERR;
                    end
                end
            end
            W_FWD: begin
                if (aw_v_q && m_axi_awready[widx_q]) aw_v_d = 1'b0;
                if (w_v_q && m_axi_wready[widx_q])   w_v_d  = 1'b0;
                if (!aw_v_d && !w_v_d) begin
                    wr_next  = W_RESP;
                    bready_d = 1'b1;
                end
            end
            W_RESP: begin
                if (m_axi_bvalid[widx_q]) begin
                    wr_next  = W_OUT;
                    bready_d = 1'b0;
                    bvalid_d = 1'b1;
                    bresp_d  = m_bresp_a[widx_q];
                end
            end
            W_OUT: begin
                if (s0_axi.bready) begin
                    wr_next   = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: wr_next = W_IDLE;
        endcase
`ifdef AXIL_DEC_TIMEOUT_EN
        if ((wr_state == W_FWD || wr_state == W_RESP) && wcnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
            wr_next  = W_OUT;
            aw_v_d   = 1'b0;
            w_v_d    = 1'b0;
            bready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = RESP_SLVERR;
        end
        if (wr_next != wr_state || !(wr_state == W_FWD || wr_state == W_RESP)) wcnt_d = '0;
        else                                                                   wcnt_d = wcnt_q + CNT_W'(1);
`endif
    end

    always_ff @(posedge s0_axi_aclk) begin
        if (!s0_axi_aresetn) begin
            wr_state  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            widx_q    <= '0;
            aw_v_q    <= 1'b0;
            w_v_q     <= 1'b0;
            bready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
`ifdef AXIL_DEC_TIMEOUT_EN
            wcnt_q    <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            wr_state  <= wr_next;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            widx_q    <= widx_d;
            aw_v_q    <= aw_v_d;
            w_v_q     <= w_v_d;
            bready_q  <= bready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
`ifdef AXIL_DEC_TIMEOUT_EN
            wcnt_q    <= wcnt_d;
`endif
        end
    end

    // ---------------- read path ----------------
    rd_state_t             rd_state, rd_next;
    logic                  arready_q, arready_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [IDX_W-1:0]      ridx_q, ridx_d;
    logic                  ar_v_q, ar_v_d, rready_q, rready_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rd_hit;
    logic [IDX_W-1:0]      rd_idx;

    axil_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .REGION_BITS(REGION_BITS),
        .NUM_TARGETS(NUM_TARGETS),
        .IDX_W      (IDX_W)
    ) u_rd_dec (
        .addr(s0_axi.araddr),
        .hit (rd_hit),
        .idx (rd_idx)
    );

    always_comb begin
        rd_next   = rd_state;
        arready_d = arready_q;
        araddr_d  = araddr_q;
        ridx_d    = ridx_q;
        ar_v_d    = ar_v_q;
        rready_d  = rready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (rd_state)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arready_q && s0_axi.arvalid) begin
                    arready_d = 1'b0;
                    araddr_d  = s0_axi.araddr;
                    ridx_d    = rd_idx;
                    if (rd_hit) begin
                        rd_next = R_FWD;
                        ar_v_d  = 1'b1;
                    end else begin
                        rd_next  = R_OUT;
                        rvalid_d = 1'b1;
                        rresp_d  = RESP_DECERR;
                        rdata_d  = '0;
                    end
                end
            end
            R_FWD: begin
                if (m_axi_arready[ridx_q]) begin
                    rd_next  = R_DATA;
                    ar_v_d   = 1'b0;
                    rready_d = 1'b1;
                end
            end
            R_DATA: begin
                if (m_axi_rvalid[ridx_q]) begin
                    rd_next  = R_OUT;
                    rready_d = 1'b0;
                    rvalid_d = 1'b1;
                    rresp_d  = m_rresp_a[ridx_q];
                    rdata_d  = m_rdata_a[ridx_q];
                end
            end
            R_OUT: begin
                if (s0_axi.rready) begin
                    rd_next   = R_IDLE;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: rd_next = R_IDLE;
        endcase
`ifdef AXIL_DEC_TIMEOUT_EN
        if ((rd_state == R_FWD || rd_state == R_DATA) && rcnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
            rd_next  = R_OUT;
            ar_v_d   = 1'b0;
            rready_d = 1'b0;
            rvalid_d = 1'b1;
            rresp_d  = RESP_SLVERR;
            rdata_d  = '0;
        end
        if (rd_next != rd_state || !(rd_state == R_FWD || rd_state == R_DATA)) rcnt_d = '0;
        else                                                                   rcnt_d = rcnt_q + CNT_W'(1);
`endif
    end

    always_ff @(posedge s0_axi_aclk) begin
        if (!s0_axi_aresetn) begin
            rd_state  <= R_IDLE;
            arready_q <= 1'b0;
            araddr_q  <= '0;
            ridx_q    <= '0;
            ar_v_q    <= 1'b0;
            rready_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
`ifdef AXIL_DEC_TIMEOUT_EN
            rcnt_q    <= '0;
`endif
        end else begin
            rd_state  <= rd_next;
            arready_q <= arready_d;
            araddr_q  <= araddr_d;
            ridx_q    <= ridx_d;
            ar_v_q    <= ar_v_d;
            rready_q  <= rready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
`ifdef AXIL_DEC_TIMEOUT_EN
            rcnt_q    <= rcnt_d;
`endif
        end
    end

    // ---------------- outputs ----------------
    assign s0_axi.awready = awready_q;
    assign s0_axi.wready  = wready_q;
    assign s0_axi.bvalid  = bvalid_q;
    assign s0_axi.bresp   = bresp_q;
    assign s0_axi.arready = arready_q;
    assign s0_axi.rvalid  = rvalid_q;
    assign s0_axi.rresp   = rresp_q;
    assign s0_axi.rdata   = rdata_q;

    assign m_axi_awaddr  = {NUM_TARGETS{awaddr_q}};
    assign m_axi_wdata   = {NUM_TARGETS{wdata_q}};
    assign m_axi_wstrb   = {NUM_TARGETS{wstrb_q}};
    assign m_axi_araddr  = {NUM_TARGETS{araddr_q}};

    // Scalar registered strobes steered to the selected slice keep the one-hot guarantee structural.
    assign m_axi_awvalid = aw_v_q   ? (NUM_TARGETS'(1) << widx_q) : '0;
    assign m_axi_wvalid  = w_v_q    ? (NUM_TARGETS'(1) << widx_q) : '0;
    assign m_axi_bready  = bready_q ? (NUM_TARGETS'(1) << widx_q) : '0;
    assign m_axi_arvalid = ar_v_q   ? (NUM_TARGETS'(1) << ridx_q) : '0;
    assign m_axi_rready  = rready_q ? (NUM_TARGETS'(1) << ridx_q) : '0;
endmodule

// File: tb/tb_axil_decoder_1ton.sv
// Directed bench for axil_decoder_1ton with two targets; the watchdog
// scenario is built only when AXIL_DEC_TIMEOUT_EN is defined.
module tb_axil_decoder_1ton;
    localparam int NT = 2;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = DW / 8;
`ifdef AXIL_DEC_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 256;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axil_decoder_1ton_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s0_axi ();

    logic [NT*AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [NT*DW-1:0] m_axi_wdata, m_axi_rdata;
    logic [NT*SW-1:0] m_axi_wstrb;
    logic [NT-1:0]    m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic [NT-1:0]    m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid;
    logic [NT*2-1:0]  m_axi_bresp, m_axi_rresp;

    int n_cmp = 0;
    int n_err = 0;

    axil_decoder_1ton #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_TARGETS(NT), .REGION_BITS(4), .TIMEOUT_CYCLES(TO)
    ) dut (
        .s0_axi_aclk   (clk),
        .s0_axi_aresetn(rst_n),
        .s0_axi        (s0_axi),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    // Outputs are sampled and inputs driven at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++; if ({s0_axi.awready, s0_axi.wready, s0_axi.arready} !== 3'b000) begin n_err++; $display("FAIL rst_readies: got %b want 000", {s0_axi.awready, s0_axi.wready, s0_axi.arready}); end
        n_cmp++; if ({s0_axi.bvalid, s0_axi.rvalid, s0_axi.bresp, s0_axi.rresp} !== 6'b0) begin n_err++; $display("FAIL rst_s0_resp: got %b want 0", {s0_axi.bvalid, s0_axi.rvalid, s0_axi.bresp, s0_axi.rresp}); end
        n_cmp++; if (s0_axi.rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", s0_axi.rdata); end
        n_cmp++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 10'b0) begin n_err++; $display("FAIL rst_m_strobes: got %b want 0", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}); end
        n_cmp++; if ({m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb} !== '0) begin n_err++; $display("FAIL rst_m_payload: got nonzero want 0"); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if ({s0_axi.awready, s0_axi.wready, s0_axi.arready} !== 3'b111) begin n_err++; $display("FAIL idle_readies: got %b want 111", {s0_axi.awready, s0_axi.wready, s0_axi.arready}); end
    endtask

    task automatic test_write_mapped();
        s0_axi.awaddr = 8'h12; s0_axi.awvalid = 1'b1;
        s0_axi.wdata = 32'hA5A5_A5A5; s0_axi.wstrb = 4'hF; s0_axi.wvalid = 1'b1;
        tick();
        s0_axi.awvalid = 1'b0; s0_axi.wvalid = 1'b0;
        n_cmp++; if ({m_axi_awvalid, m_axi_wvalid} !== 4'b1010) begin n_err++; $display("FAIL wm_fwd_valids: got %b want 1010", {m_axi_awvalid, m_axi_wvalid}); end
        n_cmp++; if (m_axi_awaddr[15:8] !== 8'h12) begin n_err++; $display("FAIL wm_awaddr: got %h want 12", m_axi_awaddr[15:8]); end
        n_cmp++; if (m_axi_wdata[63:32] !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL wm_wdata: got %h want a5a5a5a5", m_axi_wdata[63:32]); end
        n_cmp++; if (m_axi_wstrb[7:4] !== 4'hF) begin n_err++; $display("FAIL wm_wstrb: got %h want f", m_axi_wstrb[7:4]); end
        n_cmp++; if (s0_axi.awready !== 1'b0) begin n_err++; $display("FAIL wm_awready_busy: got %b want 0", s0_axi.awready); end
        m_axi_awready = 2'b10; m_axi_wready = 2'b10;
        tick();
        m_axi_awready = 2'b00; m_axi_wready = 2'b00;
        n_cmp++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 6'b000010) begin n_err++; $display("FAIL wm_resp_phase: got %b want 000010", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}); end
        m_axi_bvalid = 2'b10; m_axi_bresp = 4'b0011;
        tick();
        m_axi_bvalid = 2'b00;
        n_cmp++; if ({s0_axi.bvalid, s0_axi.bresp, m_axi_bready} !== 5'b10000) begin n_err++; $display("FAIL wm_s0_bresp: got %b want 10000", {s0_axi.bvalid, s0_axi.bresp, m_axi_bready}); end
        s0_axi.bready = 1'b1;
        tick();
        s0_axi.bready = 1'b0;
        n_cmp++; if (s0_axi.bvalid !== 1'b0) begin n_err++; $display("FAIL wm_bvalid_drop: got %b want 0", s0_axi.bvalid); end
    endtask

    task automatic test_w_before_aw();
        int bv_count;
        s0_axi.wdata = 32'h1122_3344; s0_axi.wstrb = 4'h3; s0_axi.wvalid = 1'b1;
        tick();
        s0_axi.wvalid = 1'b0;
        n_cmp++; if ({s0_axi.wready, s0_axi.awready, m_axi_wvalid} !== 4'b0100) begin n_err++; $display("FAIL wa_w_held: got %b want 0100", {s0_axi.wready, s0_axi.awready, m_axi_wvalid}); end
        tick();
        tick();
        s0_axi.awaddr = 8'h04; s0_axi.awvalid = 1'b1;
        tick();
        s0_axi.awvalid = 1'b0;
        n_cmp++; if ({m_axi_awvalid, m_axi_wvalid} !== 4'b0101) begin n_err++; $display("FAIL wa_fwd_valids: got %b want 0101", {m_axi_awvalid, m_axi_wvalid}); end
        n_cmp++; if ({m_axi_awaddr[7:0], m_axi_wdata[31:0], m_axi_wstrb[3:0]} !== {8'h04, 32'h1122_3344, 4'h3}) begin n_err++; $display("FAIL wa_payload: got %h %h %h want 04 11223344 3", m_axi_awaddr[7:0], m_axi_wdata[31:0], m_axi_wstrb[3:0]); end
        m_axi_awready = 2'b01;
        tick();
        m_axi_awready = 2'b00;
        n_cmp++; if ({m_axi_awvalid, m_axi_wvalid} !== 4'b0001) begin n_err++; $display("FAIL wa_aw_drop_only: got %b want 0001", {m_axi_awvalid, m_axi_wvalid}); end
        m_axi_wready = 2'b01;
        tick();
        m_axi_wready = 2'b00;
        n_cmp++; if ({m_axi_wvalid, m_axi_bready} !== 4'b0001) begin n_err++; $display("FAIL wa_bready: got %b want 0001", {m_axi_wvalid, m_axi_bready}); end
        m_axi_bvalid = 2'b01; m_axi_bresp = 4'b0010;
        tick();
        m_axi_bvalid = 2'b00;
        n_cmp++; if (s0_axi.bresp !== 2'b10) begin n_err++; $display("FAIL wa_bresp: got %b want 10", s0_axi.bresp); end
        s0_axi.bready = 1'b1;
        bv_count = 0;
        for (int i = 0; i < 6; i++) begin
            if (s0_axi.bvalid === 1'b1) bv_count++;
            tick();
        end
        s0_axi.bready = 1'b0;
        n_cmp++; if (bv_count !== 1) begin n_err++; $display("FAIL wa_bvalid_once: got %0d want 1", bv_count); end
    endtask

    task automatic test_unmapped_write();
        s0_axi.awaddr = 8'hF0; s0_axi.awvalid = 1'b1;
        s0_axi.wdata = 32'h0BAD_0BAD; s0_axi.wstrb = 4'hF; s0_axi.wvalid = 1'b1;
        tick();
        s0_axi.awvalid = 1'b0; s0_axi.wvalid = 1'b0;
        n_cmp++; if ({s0_axi.bvalid, s0_axi.bresp} !== 3'b111) begin n_err++; $display("FAIL uw_decerr: got %b want 111", {s0_axi.bvalid, s0_axi.bresp}); end
        n_cmp++; if ({m_axi_awvalid, m_axi_wvalid} !== 4'b0000) begin n_err++; $display("FAIL uw_no_fwd: got %b want 0000", {m_axi_awvalid, m_axi_wvalid}); end
        s0_axi.bready = 1'b1;
        tick();
        s0_axi.bready = 1'b0;
        n_cmp++; if (s0_axi.bvalid !== 1'b0) begin n_err++; $display("FAIL uw_bvalid_drop: got %b want 0", s0_axi.bvalid); end
    endtask

    task automatic test_concurrent();
        s0_axi.awaddr = 8'h00; s0_axi.awvalid = 1'b1;
        s0_axi.wdata = 32'hCAFE_F00D; s0_axi.wstrb = 4'hF; s0_axi.wvalid = 1'b1;
        s0_axi.araddr = 8'h14; s0_axi.arvalid = 1'b1;
        tick();
        s0_axi.awvalid = 1'b0; s0_axi.wvalid = 1'b0; s0_axi.arvalid = 1'b0;
        n_cmp++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid} !== 6'b010110) begin n_err++; $display("FAIL cc_fwd_valids: got %b want 010110", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}); end
        n_cmp++; if (m_axi_araddr[15:8] !== 8'h14) begin n_err++; $display("FAIL cc_araddr: got %h want 14", m_axi_araddr[15:8]); end
        m_axi_awready = 2'b01; m_axi_wready = 2'b01; m_axi_arready = 2'b10;
        tick();
        m_axi_awready = 2'b00; m_axi_wready = 2'b00; m_axi_arready = 2'b00;
        n_cmp++; if ({m_axi_bready, m_axi_rready, m_axi_arvalid} !== 6'b011000) begin n_err++; $display("FAIL cc_resp_phase: got %b want 011000", {m_axi_bready, m_axi_rready, m_axi_arvalid}); end
        m_axi_rdata = {32'hDEAD_BEEF, 32'h1234_5678}; m_axi_rresp = 4'b0011; m_axi_rvalid = 2'b10;
        m_axi_bresp = 4'b0001; m_axi_bvalid = 2'b01;
        tick();
        m_axi_rvalid = 2'b00; m_axi_bvalid = 2'b00;
        n_cmp++; if ({s0_axi.rvalid, s0_axi.rresp} !== 3'b100) begin n_err++; $display("FAIL cc_rresp: got %b want 100", {s0_axi.rvalid, s0_axi.rresp}); end
        n_cmp++; if (s0_axi.rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL cc_rdata: got %h want deadbeef", s0_axi.rdata); end
        n_cmp++; if ({s0_axi.bvalid, s0_axi.bresp} !== 3'b101) begin n_err++; $display("FAIL cc_bresp: got %b want 101", {s0_axi.bvalid, s0_axi.bresp}); end
        s0_axi.rready = 1'b1; s0_axi.bready = 1'b1;
        tick();
        s0_axi.rready = 1'b0; s0_axi.bready = 1'b0;
        n_cmp++; if ({s0_axi.rvalid, s0_axi.bvalid, s0_axi.arready} !== 3'b001) begin n_err++; $display("FAIL cc_done: got %b want 001", {s0_axi.rvalid, s0_axi.bvalid, s0_axi.arready}); end
    endtask

    task automatic test_bready_stall();
        s0_axi.awaddr = 8'h1C; s0_axi.awvalid = 1'b1;
        s0_axi.wdata = 32'h0000_0001; s0_axi.wstrb = 4'h1; s0_axi.wvalid = 1'b1;
        tick();
        s0_axi.awvalid = 1'b0; s0_axi.wvalid = 1'b0;
        m_axi_awready = 2'b10; m_axi_wready = 2'b10;
        tick();
        m_axi_awready = 2'b00; m_axi_wready = 2'b00;
        m_axi_bresp = 4'b1000; m_axi_bvalid = 2'b10;
        tick();
        m_axi_bvalid = 2'b00;
        s0_axi.awaddr = 8'h00; s0_axi.awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({s0_axi.bvalid, s0_axi.bresp} !== 3'b110) begin n_err++; $display("FAIL bs_hold_%0d: got %b want 110", i, {s0_axi.bvalid, s0_axi.bresp}); end
            n_cmp++; if ({s0_axi.awready, m_axi_awvalid} !== 3'b000) begin n_err++; $display("FAIL bs_no_accept_%0d: got %b want 000", i, {s0_axi.awready, m_axi_awvalid}); end
            tick();
        end
        s0_axi.bready = 1'b1; s0_axi.awvalid = 1'b0;
        tick();
        s0_axi.bready = 1'b0;
        n_cmp++; if ({s0_axi.bvalid, s0_axi.awready} !== 2'b01) begin n_err++; $display("FAIL bs_release: got %b want 01", {s0_axi.bvalid, s0_axi.awready}); end
    endtask

    task automatic test_unmapped_read();
        s0_axi.araddr = 8'h30; s0_axi.arvalid = 1'b1;
        tick();
        s0_axi.arvalid = 1'b0;
        n_cmp++; if ({s0_axi.rvalid, s0_axi.rresp, s0_axi.arready} !== 4'b1110) begin n_err++; $display("FAIL ur_decerr: got %b want 1110", {s0_axi.rvalid, s0_axi.rresp, s0_axi.arready}); end
        n_cmp++; if (s0_axi.rdata !== 32'h0) begin n_err++; $display("FAIL ur_rdata: got %h want 0", s0_axi.rdata); end
        n_cmp++; if (m_axi_arvalid !== 2'b00) begin n_err++; $display("FAIL ur_no_arvalid: got %b want 00", m_axi_arvalid); end
        s0_axi.rready = 1'b1;
        tick();
        s0_axi.rready = 1'b0;
        n_cmp++; if ({s0_axi.rvalid, s0_axi.arready, m_axi_arvalid} !== 4'b0100) begin n_err++; $display("FAIL ur_done: got %b want 0100", {s0_axi.rvalid, s0_axi.arready, m_axi_arvalid}); end
    endtask

    task automatic test_reset_mid();
        s0_axi.awaddr = 8'h08; s0_axi.awvalid = 1'b1;
        s0_axi.wdata = 32'h5555_AAAA; s0_axi.wstrb = 4'hF; s0_axi.wvalid = 1'b1;
        s0_axi.araddr = 8'h10; s0_axi.arvalid = 1'b1;
        tick();
        s0_axi.awvalid = 1'b0; s0_axi.wvalid = 1'b0; s0_axi.arvalid = 1'b0;
        m_axi_awready = 2'b01; m_axi_wready = 2'b01;
        tick();
        m_axi_awready = 2'b00; m_axi_wready = 2'b00;
        n_cmp++; if ({m_axi_bready, m_axi_arvalid} !== 4'b0110) begin n_err++; $display("FAIL rm_busy: got %b want 0110", {m_axi_bready, m_axi_arvalid}); end
        rst_n = 1'b0;
        tick();
        n_cmp++; if ({m_axi_bready, m_axi_arvalid, s0_axi.awready, s0_axi.wready, s0_axi.arready} !== 7'b0) begin n_err++; $display("FAIL rm_cleared: got %b want 0", {m_axi_bready, m_axi_arvalid, s0_axi.awready, s0_axi.wready, s0_axi.arready}); end
        n_cmp++; if ({m_axi_awaddr, m_axi_araddr, m_axi_wdata} !== '0) begin n_err++; $display("FAIL rm_payload: got nonzero want 0"); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if ({s0_axi.awready, s0_axi.arready, s0_axi.bvalid} !== 3'b110) begin n_err++; $display("FAIL rm_recover: got %b want 110", {s0_axi.awready, s0_axi.arready, s0_axi.bvalid}); end
    endtask

`ifdef AXIL_DEC_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        s0_axi.awaddr = 8'h04; s0_axi.awvalid = 1'b1;
        s0_axi.wdata = 32'h0F0F_0F0F; s0_axi.wstrb = 4'hF; s0_axi.wvalid = 1'b1;
        tick();
        s0_axi.awvalid = 1'b0; s0_axi.wvalid = 1'b0;
        m_axi_awready = 2'b01; m_axi_wready = 2'b01;
        tick();
        m_axi_awready = 2'b00; m_axi_wready = 2'b00;
        n = 0;
        while (s0_axi.bvalid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        n_cmp++; if (n !== TO + 1) begin n_err++; $display("FAIL to_latency: got %0d want %0d", n, TO + 1); end
        n_cmp++; if ({s0_axi.bvalid, s0_axi.bresp, m_axi_bready} !== 5'b11000) begin n_err++; $display("FAIL to_slverr: got %b want 11000", {s0_axi.bvalid, s0_axi.bresp, m_axi_bready}); end
        s0_axi.bready = 1'b1;
        tick();
        s0_axi.bready = 1'b0;
    endtask
`endif

    initial begin
        s0_axi.awaddr = '0; s0_axi.awvalid = 1'b0; s0_axi.wdata = '0; s0_axi.wstrb = '0;
        s0_axi.wvalid = 1'b0; s0_axi.bready = 1'b0; s0_axi.araddr = '0; s0_axi.arvalid = 1'b0;
        s0_axi.rready = 1'b0;
        m_axi_awready = '0; m_axi_wready = '0; m_axi_bvalid = '0; m_axi_bresp = '0;
        m_axi_arready = '0; m_axi_rvalid = '0; m_axi_rresp = '0; m_axi_rdata = '0;
        test_reset();
        test_write_mapped();
        test_w_before_aw();
        test_unmapped_write();
        test_concurrent();
        test_bready_stall();
        test_unmapped_read();
`ifdef AXIL_DEC_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
